// File: rtl/alu_output_stage_pattern_detect.sv
// Output register stage after the 30-bit SIMD ALU. It registers P and the lane carries,
// and produces pattern/pattern-bar detect and overflow/underflow flags per SIMD segment.
module alu_output_stage_pattern_detect #(
  parameter int P_WIDTH = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CEP,
  input  logic               RSTP,
  input  logic [1:0]         USE_SIMD,
  input  logic [P_WIDTH-1:0] S,
  input  logic [7:0]         carry_bus,
  input  logic [P_WIDTH-1:0] PATTERN,
  input  logic [P_WIDTH-1:0] MASK,
  input  logic               AUTORESET_PATDET,
  output logic [P_WIDTH-1:0] P,
  output logic [3:0]         CARRYOUT,
  output logic [3:0]         PATTERNDETECT,
  output logic [3:0]         PATTERNBDETECT,
  output logic [3:0]         OVERFLOW,
  output logic [3:0]         UNDERFLOW
);

  function automatic logic [P_WIDTH-1:0] lane_bits(input int k);
    logic [P_WIDTH-1:0] m;
    m = '0;
    case (k)
      0:       m[11:0]  = '1;
      1:       m[17:12] = '1;
      2:       m[23:18] = '1;
      default: m[29:24] = '1;
    endcase
    return m;
  endfunction

  logic [P_WIDTH-1:0] p_q, p_d;
  logic [3:0]         co_q, co_d;
  logic [3:0]         pd_q, pd_d;
  logic [3:0]         pbd_q, pbd_d;
  logic [3:0]         of_q, of_d;
  logic [3:0]         uf_q, uf_d;
  logic [1:0]         mode_q, mode_d;

  logic [1:0]         mode_n;
  logic [1:0]         owner [4];
  logic [P_WIDTH-1:0] seg_mask [4];
  logic [3:0]         is_top;
  logic [3:0]         ar_seg;
  logic [P_WIDTH-1:0] p_n;
  logic [3:0]         pd_n, pbd_n, of_n, uf_n, co_n;
  logic [3:0]         pd_past, pbd_past;

  always_comb begin
    mode_n = (USE_SIMD == 2'b11) ? 2'b00 : USE_SIMD;

    // owner[k] is the top lane of the segment that lane k belongs to
    for (int k = 0; k < 4; k++) begin
      case (mode_n)
        2'b01:   owner[k] = (k < 2) ? 2'd1 : 2'd3;
        2'b10:   owner[k] = 2'(k);
        default: owner[k] = 2'd3;
      endcase
    end

    for (int t = 0; t < 4; t++) begin
      seg_mask[t] = '0;
      for (int k = 0; k < 4; k++)
        if (owner[k] == 2'(t)) seg_mask[t] = seg_mask[t] | lane_bits(k);
      is_top[t] = (owner[t] == 2'(t));
      ar_seg[t] = AUTORESET_PATDET & pd_q[t] & is_top[t];
    end

    p_n = S;
    for (int k = 0; k < 4; k++)
      if (ar_seg[owner[k]]) p_n = p_n & ~lane_bits(k);

    // PD/PBD registers double as the history; a mode change invalidates them
    pd_past  = (mode_n != mode_q) ? 4'b0 : pd_q;
    pbd_past = (mode_n != mode_q) ? 4'b0 : pbd_q;

    for (int t = 0; t < 4; t++) begin
      pd_n[t]  = is_top[t] & ~ar_seg[t] &
                 (((p_n ^ PATTERN) & ~MASK & seg_mask[t]) == '0);
      pbd_n[t] = is_top[t] & ~ar_seg[t] &
                 (((p_n ^ ~PATTERN) & ~MASK & seg_mask[t]) == '0);
      co_n[t]  = is_top[t] & ~ar_seg[t] & carry_bus[2*t+1];
      of_n[t]  = is_top[t] & ~ar_seg[t] & pd_past[t]  & ~pd_n[t] & ~pbd_n[t];
      uf_n[t]  = is_top[t] & ~ar_seg[t] & pbd_past[t] & ~pd_n[t] & ~pbd_n[t];
    end

    p_d    = p_q;
    co_d   = co_q;
    pd_d   = pd_q;
    pbd_d  = pbd_q;
    of_d   = of_q;
    uf_d   = uf_q;
    mode_d = mode_q;
    if (RSTP) begin
      p_d    = '0;
      co_d   = '0;
      pd_d   = '0;
      pbd_d  = '0;
      of_d   = '0;
      uf_d   = '0;
      mode_d = '0;
    end else if (CEP) begin
      p_d    = p_n;
      co_d   = co_n;
      pd_d   = pd_n;
      pbd_d  = pbd_n;
      of_d   = of_n;
      uf_d   = uf_n;
      mode_d = mode_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      co_q   <= '0;
      pd_q   <= '0;
      pbd_q  <= '0;
      of_q   <= '0;
      uf_q   <= '0;
      mode_q <= '0;
    end else begin
      p_q    <= p_d;
      co_q   <= co_d;
      pd_q   <= pd_d;
      pbd_q  <= pbd_d;
      of_q   <= of_d;
      uf_q   <= uf_d;
      mode_q <= mode_d;
    end
  end

  assign P              = p_q;
  assign CARRYOUT       = co_q;
  assign PATTERNDETECT  = pd_q;
  assign PATTERNBDETECT = pbd_q;
  assign OVERFLOW       = of_q;
  assign UNDERFLOW      = uf_q;

endmodule
